// File: rtl/voice_mixer_scheduler.sv
// -----------------------------------------------------------------------------
// voice_mixer_scheduler
//
// Shares one sine-lookup ROM among NUM_VOICES note voices. Each frame it
// snapshots the key levels, walks every voice once (one ROM read per cycle),
// advances or clears the per-voice phase, sums the ROM samples of the active
// voices, and hands the left-justified mix to the audio controller.
//
// Frame: IDLE -> SCAN (NUM_VOICES cycles) -> DRAIN -> OUT (held while the
// controller has no room). Back-to-back period is NUM_VOICES+3 cycles.
//
// Handshake: in OUT the sample is offered; write_audio_out is high in exactly
// the cycles where state is OUT and audio_out_allowed is high, and the FSM
// leaves OUT on that same clock edge, so every strobe is one accepted sample.
//
// Ports:
//   CLOCK_50                 clock
//   resetn                   asynchronous active-low reset
//   key_en[NUM_VOICES]       note request levels (sampled in IDLE)
//   inc_wr/inc_sel/inc_data  phase-increment config write port
//   rom_addr                 shared ROM address (held outside SCAN)
//   rom_data                 ROM data, one cycle after rom_addr
//   audio_out_allowed        controller FIFO has space
//   write_audio_out          one-cycle sample write strobe
//   left/right_channel_audio_out  mixed sample (identical)
//   busy                     FSM not in IDLE
//   active_count             popcount of the current frame snapshot
// -----------------------------------------------------------------------------
module voice_mixer_scheduler #(
  parameter int NUM_VOICES = 10,
  parameter int PHASE_W    = 32,
  parameter int ROM_AW     = 10,
  parameter int SAMPLE_W   = 16,
  parameter int GUARD_BITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic [NUM_VOICES-1:0] key_en,
  input  logic                  inc_wr,
  input  logic [3:0]            inc_sel,
  input  logic [PHASE_W-1:0]    inc_data,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [SAMPLE_W-1:0]   rom_data,
  input  logic                  audio_out_allowed,
  output logic                  write_audio_out,
  output logic [31:0]           left_channel_audio_out,
  output logic [31:0]           right_channel_audio_out,
  output logic                  busy,
  output logic [3:0]            active_count
);

  localparam int AW    = SAMPLE_W + GUARD_BITS;
  localparam int SHIFT = 32 - AW;
  localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [VW-1:0]         v_q, v_d;
  logic [NUM_VOICES-1:0] snap_q, snap_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            key_pop;
  logic [AW-1:0]         acc_q, acc_d;
  logic [AW-1:0]         acc_sum;
  logic                  pend_q, pend_d;
  logic [ROM_AW-1:0]     hold_q, hold_d;
  logic [ROM_AW-1:0]     scan_addr;
  logic [31:0]           out_q, out_d;
  logic [31:0]           acc_ext;

  logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]    inc_q   [NUM_VOICES];

  // Address of the voice being scanned: phase before this frame's advance.
  assign scan_addr = phase_q[v_q][PHASE_W-1 -: ROM_AW];

  // pend_q marks that the ROM word arriving now belongs to a snapped voice
  // scanned last cycle; unsnapped voices contribute nothing.
  assign acc_sum = acc_q + (pend_q ? {{GUARD_BITS{rom_data[SAMPLE_W-1]}}, rom_data}
                                   : {AW{1'b0}});

  // Left-justify the signed sum into the 32-bit channel word.
  assign acc_ext = {{SHIFT{acc_sum[AW-1]}}, acc_sum} << SHIFT;

  always_comb begin
    key_pop = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      key_pop = key_pop + {3'b000, key_en[i]};
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    acc_d   = acc_sum;
    pend_d  = 1'b0;
    hold_d  = hold_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        if (audio_out_allowed) begin
          snap_d  = key_en;
          cnt_d   = key_pop;
          v_d     = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        hold_d = scan_addr;
        pend_d = snap_q[v_q];
        if (v_q == LAST_V) begin
          state_d = S_DRAIN;
        end else begin
          v_d = v_q + 1'b1;
        end
      end
      S_DRAIN: begin
        out_d   = acc_ext;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (audio_out_allowed) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      v_q     <= '0;
      snap_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      pend_q  <= 1'b0;
      hold_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end

  // Per-voice tuning words and phase accumulators. The phase update reads
  // inc_q before any same-cycle config write lands, so a colliding write
  // takes effect from the next frame.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
      end
    end else begin
      if (inc_wr && (32'(inc_sel) < NUM_VOICES)) begin
        inc_q[inc_sel] <= inc_data;
      end
      if (state_q == S_SCAN) begin
        // A released voice restarts from address 0 when pressed again.
        phase_q[v_q] <= snap_q[v_q] ? (phase_q[v_q] + inc_q[v_q]) : '0;
      end
    end
  end

  assign rom_addr                = (state_q == S_SCAN) ? scan_addr : hold_q;
  assign write_audio_out         = (state_q == S_OUT) && audio_out_allowed;
  assign left_channel_audio_out  = out_q;
  assign right_channel_audio_out = out_q;
  assign busy                    = (state_q != S_IDLE);
  assign active_count            = cnt_q;

endmodule

// File: tb/tb_voice_mixer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_voice_mixer_scheduler
//
// Directed bench for voice_mixer_scheduler. A registered ROM model returns
// either rom[a] = a or rom[a] = -1. Inputs change 1 ns after the rising edge
// and outputs are sampled there too, so nothing races the clock.
// -----------------------------------------------------------------------------
module tb_voice_mixer_scheduler;

  logic        clk;
  logic        resetn;
  logic [9:0]  key_en;
  logic        inc_wr;
  logic [3:0]  inc_sel;
  logic [31:0] inc_data;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left_out;
  logic [31:0] right_out;
  logic        busy;
  logic [3:0]  active_count;

  logic        rom_neg;
  int          checks;
  int          errors;
  int          strobes;
  int          strobes_before;
  logic [31:0] smp;
  int          lat;

  voice_mixer_scheduler dut (
    .CLOCK_50                (clk),
    .resetn                  (resetn),
    .key_en                  (key_en),
    .inc_wr                  (inc_wr),
    .inc_sel                 (inc_sel),
    .inc_data                (inc_data),
    .rom_addr                (rom_addr),
    .rom_data                (rom_data),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_out),
    .right_channel_audio_out (right_out),
    .busy                    (busy),
    .active_count            (active_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered sine-ROM stand-in: data valid one cycle after the address.
  always @(posedge clk) begin
    rom_data <= rom_neg ? 16'hFFFF : {6'b000000, rom_addr};
  end

  // Count every accepted write strobe.
  initial strobes = 0;
  always @(posedge clk) begin
    if (write_audio_out === 1'b1) strobes <= strobes + 1;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance until the next write strobe (bounded); returns sample and cycles.
  task automatic wait_strobe(output logic [31:0] s, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (write_audio_out !== 1'b1 && n < 100);
    check("strobe_seen", {31'b0, write_audio_out}, 32'd1);
    s = left_out;
  endtask

  task automatic cfg(input logic [3:0] sel, input logic [31:0] data);
    inc_sel  = sel;
    inc_data = data;
    inc_wr   = 1'b1;
    tick();
    inc_wr   = 1'b0;
  endtask

  task automatic do_reset();
    resetn            = 1'b0;
    audio_out_allowed = 1'b0;
    key_en            = '0;
    inc_wr            = 1'b0;
    rom_neg           = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    resetn            = 1'b1;
    key_en            = '0;
    inc_wr            = 1'b0;
    inc_sel           = '0;
    inc_data          = '0;
    audio_out_allowed = 1'b0;
    rom_neg           = 1'b0;
    #2 resetn = 1'b0;

    // ---- reset state ----
    tick(); tick(); tick();
    check("rst_write", {31'b0, write_audio_out}, 32'd0);
    check("rst_left", left_out, 32'd0);
    check("rst_right", right_out, 32'd0);
    check("rst_rom_addr", {22'b0, rom_addr}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_active", {28'b0, active_count}, 32'd0);
    resetn = 1'b1;
    tick();

    // ---- single voice: voice 5, address +1 per frame ----
    cfg(4'd5, 32'h0040_0000);
    key_en            = 10'b00_0010_0000;
    audio_out_allowed = 1'b1;
    wait_strobe(smp, lat);
    check("single_latency", 32'(lat), 32'd12);
    check("single_s0", smp, 32'd0);
    check("single_right0", right_out, 32'd0);
    check("single_active", {28'b0, active_count}, 32'd1);
    for (int k = 1; k < 4; k++) begin
      wait_strobe(smp, lat);
      check("single_period", 32'(lat), 32'd13);
      check("single_sample", smp, 32'(k) << 12);
    end

    // ---- backpressure: drop allowed at DRAIN for 5 cycles ----
    repeat (12) tick();
    check("bp_drain_busy", {31'b0, busy}, 32'd1);
    check("bp_drain_write", {31'b0, write_audio_out}, 32'd0);
    audio_out_allowed = 1'b0;
    strobes_before    = strobes;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_write", {31'b0, write_audio_out}, 32'd0);
      check("bp_hold_left", left_out, 32'd4 << 12);
      check("bp_hold_busy", {31'b0, busy}, 32'd1);
    end
    audio_out_allowed = 1'b1;
    #1;
    check("bp_release_write", {31'b0, write_audio_out}, 32'd1);
    tick();
    check("bp_after_write", {31'b0, write_audio_out}, 32'd0);
    check("bp_after_busy", {31'b0, busy}, 32'd0);
    check("bp_one_strobe", 32'(strobes - strobes_before), 32'd1);

    // ---- asynchronous reset in the middle of SCAN ----
    tick(); tick(); tick();
    check("midscan_busy", {31'b0, busy}, 32'd1);
    strobes_before = strobes;
    resetn = 1'b0;
    #1;
    check("midrst_write", {31'b0, write_audio_out}, 32'd0);
    check("midrst_left", left_out, 32'd0);
    check("midrst_right", right_out, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_rom_addr", {22'b0, rom_addr}, 32'd0);
    check("midrst_active", {28'b0, active_count}, 32'd0);
    tick();
    tick();
    check("midrst_no_strobe", 32'(strobes - strobes_before), 32'd0);
    resetn = 1'b1;
    wait_strobe(smp, lat);
    check("postrst_latency", 32'(lat), 32'd12);
    check("postrst_sample", smp, 32'd0);

    // ---- two voices, 0 and 9 ----
    do_reset();
    cfg(4'd0, 32'h0040_0000);
    cfg(4'd9, 32'h0040_0000);
    key_en            = 10'b10_0000_0001;
    audio_out_allowed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(smp, lat);
      check("two_sample", smp, 32'(2 * k) << 12);
    end
    check("two_active", {28'b0, active_count}, 32'd2);

    // ---- all ten voices reading -1 ----
    do_reset();
    rom_neg           = 1'b1;
    key_en            = 10'h3FF;
    audio_out_allowed = 1'b1;
    wait_strobe(smp, lat);
    check("neg_left", smp, 32'hFFFF_6000);
    check("neg_right", right_out, 32'hFFFF_6000);
    check("neg_active", {28'b0, active_count}, 32'd10);

    // ---- zero active voices still writes silence ----
    key_en = '0;
    wait_strobe(smp, lat);
    check("zero_period", 32'(lat), 32'd13);
    check("zero_sample", smp, 32'd0);
    check("zero_active", {28'b0, active_count}, 32'd0);

    // ---- phase wrap: address alternates 0, 512 ----
    do_reset();
    cfg(4'd2, 32'h8000_0000);
    key_en            = 10'b00_0000_0100;
    audio_out_allowed = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_strobe(smp, lat);
      check("wrap_sample", smp, ((k % 2) == 1) ? (32'd512 << 12) : 32'd0);
    end

    // ---- release for one frame, then re-press ----
    do_reset();
    cfg(4'd5, 32'h0040_0000);
    key_en            = 10'b00_0010_0000;
    audio_out_allowed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(smp, lat);
      check("rel_pre_sample", smp, 32'(k) << 12);
    end
    key_en = '0;
    wait_strobe(smp, lat);
    check("rel_off_sample", smp, 32'd0);
    check("rel_off_active", {28'b0, active_count}, 32'd0);
    key_en = 10'b00_0010_0000;
    wait_strobe(smp, lat);
    check("rel_repress_s0", smp, 32'd0);
    wait_strobe(smp, lat);
    check("rel_repress_s1", smp, 32'd1 << 12);

    // ---- config write colliding with the scan of voice 3 ----
    do_reset();
    cfg(4'd3, 32'h0040_0000);
    key_en            = 10'b00_0000_1000;
    audio_out_allowed = 1'b1;
    tick(); tick(); tick(); tick();
    check("coll_scan_addr", {22'b0, rom_addr}, 32'd0);
    inc_sel  = 4'd3;
    inc_data = 32'h0080_0000;
    inc_wr   = 1'b1;
    tick();
    inc_wr   = 1'b0;
    wait_strobe(smp, lat);
    check("coll_f0", smp, 32'd0);
    wait_strobe(smp, lat);
    check("coll_f1_old_inc", smp, 32'd1 << 12);
    wait_strobe(smp, lat);
    check("coll_f2_new_inc", smp, 32'd3 << 12);

    // ---- out-of-range config select is ignored ----
    cfg(4'd12, 32'hFFFF_FFFF);
    wait_strobe(smp, lat);
    check("badsel_f3", smp, 32'd5 << 12);
    wait_strobe(smp, lat);
    check("badsel_f4", smp, 32'd7 << 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
